// File: rtl/aes_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helpers for the AES-128 key schedule.
package aes_pkg;

    localparam int WORD_SIZE  = 8;
    localparam int ARRAY_SIZE = 16;
    localparam int NR         = 10;

    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_OUT = 2'd1,
        FINISH   = 2'd2
    } ks_state_t;

    // Multiply by x in GF(2^8) modulo the AES polynomial; used to step rcon.
    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: one byte in, substituted byte out.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);

    // Byte 0x00 maps from the most significant lane, so row 0 sits at the top.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] idx;

    always_comb begin
        idx = {~a, 3'b000};
        s   = SBOX[idx +: 8];
    end

endmodule

// File: rtl/key_expansion.sv
// Iterative AES-128 key schedule: emits round keys 0..NR one per valid/ready handshake,
// deriving each next key from the current one so no expanded-key storage is needed.
module key_expansion
    import aes_pkg::*;
#(
    parameter int word_size  = WORD_SIZE,
    parameter int array_size = ARRAY_SIZE,
    parameter int NR_ROUNDS  = NR
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [word_size*array_size-1:0]  key_in,
    input  logic                             rk_ready,
    output logic [word_size*array_size-1:0]  rk_out,
    output logic [3:0]                       rk_round,
    output logic                             rk_valid,
    output logic                             busy,
    output logic                             done
);

    localparam int KW = word_size * array_size;

    ks_state_t   state;
    logic [7:0]  rcon;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_w3, sub_w3, t_word;
    logic [31:0] n0, n1, n2, n3;
    logic [KW-1:0] next_key;
    logic        handshake;

    assign w0 = rk_out[127:96];
    assign w1 = rk_out[95:64];
    assign w2 = rk_out[63:32];
    assign w3 = rk_out[31:0];

    assign rot_w3 = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .a (rot_w3[8*i +: 8]),
            .s (sub_w3[8*i +: 8])
        );
    end

    // Each word depends on the one before it, forming a short XOR chain.
    always_comb begin
        t_word   = sub_w3 ^ {rcon, 24'h000000};
        n0       = w0 ^ t_word;
        n1       = w1 ^ n0;
        n2       = w2 ^ n1;
        n3       = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    assign handshake = rk_valid & rk_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rk_out   <= '0;
            rk_round <= '0;
            rk_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rcon     <= RCON_INIT;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rk_out   <= key_in;
                        rk_round <= '0;
                        rcon     <= RCON_INIT;
                        rk_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= LOAD_OUT;
                    end
                end
                LOAD_OUT: begin
                    if (handshake) begin
                        if (rk_round == 4'(NR_ROUNDS)) begin
                            // Last key stays on rk_out after acceptance.
                            rk_valid <= 1'b0;
                            done     <= 1'b1;
                            state    <= FINISH;
                        end else begin
                            rk_out   <= next_key;
                            rk_round <= rk_round + 4'd1;
                            rcon     <= xtime(rcon);
                        end
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_expansion.sv
// Scoreboard bench for key_expansion against a word-level FIPS-197 expansion model.
module tb_key_expansion;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         busy;
    logic         done;

    typedef struct {
        logic [3:0]   round;
        logic [127:0] key;
    } exp_t;

    exp_t         exp_q[$];
    int           total = 0;
    int           bad = 0;
    int           done_count = 0;
    int           done_target = 0;
    int           hs_count = 0;
    logic         prev_done = 1'b0;
    bit           random_ready = 0;
    bit           force_low = 0;
    logic [7:0]   sbox_tab[256];
    logic [127:0] model_rk[11];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;

    key_expansion dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_round (rk_round),
        .rk_valid (rk_valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] a = a_in;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse then the affine map.
    function automatic void buildSbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] b;
            logic [7:0] r;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            r = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
            sbox_tab[x] = r;
        end
    endfunction

    function automatic void expandModel(input logic [127:0] key);
        logic [31:0] w[44];
        logic [31:0] temp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {sbox_tab[temp[31:24]], sbox_tab[temp[23:16]], sbox_tab[temp[15:8]], sbox_tab[temp[7:0]]};
                temp ^= {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // kind: 0 = model only, 1 = FIPS vector constants, 2 = all-zero key constant
    task automatic applyStimulus(input logic [127:0] key, input int kind);
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        checkOutput("idle_before_start", busy, 1'b0);
        expandModel(key);
        if (kind == 1) begin
            model_rk[1]  = FIPS_R1;
            model_rk[10] = FIPS_R10;
        end else if (kind == 2) begin
            model_rk[1] = ZERO_R1;
        end
        for (int r = 0; r < 11; r++) exp_q.push_back('{round: 4'(r), key: model_rk[r]});
        done_target = done_count + 1;
        key_in = key;
        start  = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        checkOutput("start_latency_valid", rk_valid, 1'b1);
        checkOutput("start_round0", rk_round, 4'd0);
        checkOutput("start_busy", busy, 1'b1);
    endtask

    task automatic waitRound(input int r);
        for (int i = 0; i < 200; i++) begin
            if (rk_valid && rk_round == 4'(r)) return;
            @(posedge clk); #2;
        end
        checkOutput("wait_round_timeout", 128'(rk_round), 128'(r));
    endtask

    task automatic waitDone();
        for (int i = 0; i < 3000; i++) begin
            if (done_count >= done_target) return;
            @(posedge clk); #2;
        end
        checkOutput("wait_done_timeout", 128'(done_count), 128'(done_target));
    endtask

    initial begin
        rk_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (force_low)         rk_ready = 1'b0;
            else if (random_ready) rk_ready = ($urandom_range(0, 3) != 0);
            else                   rk_ready = 1'b1;
        end
    end

    // Monitor: whenever a key is presented it must be the head of the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            hs_count = 0;
            exp_q.delete();
        end else begin
            if (rk_valid) begin
                checkOutput("valid_implies_busy", busy, 1'b1);
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_valid", rk_valid, 1'b0);
                end else begin
                    checkOutput("rk_round", rk_round, exp_q[0].round);
                    checkOutput("rk_out", rk_out, exp_q[0].key);
                    if (rk_ready) begin
                        void'(exp_q.pop_front());
                        hs_count++;
                    end
                end
            end
            if (done) begin
                checkOutput("handshakes_per_start", 128'(hs_count), 128'd11);
                checkOutput("queue_drained", 128'(exp_q.size()), 128'd0);
                checkOutput("done_single_cycle", prev_done, 1'b0);
                hs_count = 0;
                done_count++;
            end
        end
        prev_done = done;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int expected_done;
        buildSbox();
        rst    = 1'b1;
        start  = 1'b0;
        key_in = '0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_rk_out", rk_out, 128'h0);
        checkOutput("reset_rk_round", rk_round, 4'd0);
        checkOutput("reset_rk_valid", rk_valid, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_done", done, 1'b0);
        rst = 1'b0;

        $display("[TB] FIPS-197 vector, consumer always ready");
        applyStimulus(FIPS_KEY, 1);
        waitDone();

        $display("[TB] stall at round 3, stray start at round 5");
        applyStimulus(FIPS_KEY, 1);
        waitRound(2);
        force_low = 1;
        repeat (5) begin
            @(posedge clk); #2;
        end
        force_low = 0;
        waitRound(5);
        key_in = {$urandom, $urandom, $urandom, $urandom};
        start  = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        waitDone();

        $display("[TB] reset abort at round 7, then all-zero key");
        expected_done = done_count;
        applyStimulus(FIPS_KEY, 1);
        waitRound(7);
        rst = 1'b1;
        @(posedge clk); #2;
        checkOutput("abort_rk_valid", rk_valid, 1'b0);
        checkOutput("abort_rk_round", rk_round, 4'd0);
        checkOutput("abort_rk_out", rk_out, 128'h0);
        checkOutput("abort_busy", busy, 1'b0);
        rst = 1'b0;
        @(posedge clk); #2;
        checkOutput("abort_no_done", 128'(done_count), 128'(expected_done));
        applyStimulus(128'h0, 2);
        waitDone();

        $display("[TB] random keys with throttled consumer");
        random_ready = 1;
        expected_done = done_count;
        for (int s = 0; s < 100; s++) begin
            applyStimulus({$urandom, $urandom, $urandom, $urandom}, 0);
            waitDone();
            expected_done++;
        end
        random_ready = 0;
        repeat (4) @(posedge clk);
        #2;
        checkOutput("schedules_completed", 128'(done_count), 128'(expected_done));
        checkOutput("final_idle", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
